// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width encodings, FSM
// states and the lane-selection helpers used by the top and lsu_align.
package lsu_pkg;

  // RV32I funct3 width/sign encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size as encoded in funct3[1:0]
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Fixed lane offsets for halfword/word accesses
  localparam logic [1:0] LANE_W    = 2'b00;
  localparam logic [1:0] LANE_H_LO = 2'b00;
  localparam logic [1:0] LANE_H_HI = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR
  } lsu_state_t;

  // Byte lane of the access: bytes use addr[1:0], halfwords addr[1],
  // words are always lane 0 (low address bits are forced aligned).
  function automatic logic [1:0] lane_sel(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic [1:0] lane;
    case (size)
      SIZE_B:  lane = addr_lo;
      SIZE_H:  lane = addr_lo[1] ? LANE_H_HI : LANE_H_LO;
      default: lane = LANE_W;
    endcase
    return lane;
  endfunction

  // funct3 legality: loads allow B/H/W/BU/HU, stores only B/H/W
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    if (we) ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
    return ok;
  endfunction

  // Halfword needs addr[0]=0, word needs addr[1:0]=0
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational data path of the load/store unit: extracts and extends a
// load lane from a memory word, and merges a byte/halfword store lane into
// a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [1:0]  lane;
  logic [4:0]  sh;
  logic [31:0] shifted;

  // Lane shift, load extension and store lane merge
  always_comb begin
    lane       = lane_sel(funct3[1:0], addr_lo);
    sh         = {lane, 3'b000};
    shifted    = word >> sh;
    load_data  = '0;
    merge_data = word;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'b0, shifted[7:0]};
      F3_HU:   load_data = {16'b0, shifted[15:0]};
      default: load_data = '0;
    endcase
    case (funct3[1:0])
      SIZE_B:  merge_data = (word & ~(32'h0000_00FF << sh)) | ({24'b0, wdata[7:0]} << sh);
      SIZE_H:  merge_data = (word & ~(32'h0000_FFFF << sh)) | ({16'b0, wdata} << sh);
      default: merge_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts byte-addressed RV32I load/store requests into
// word accesses on a 256x32 memory without byte enables (sub-word stores
// via read-modify-write).
// Optional: define LSU_MISALIGN_TRAP_EN to flag misaligned halfword/word
// requests with resp_err; otherwise such accesses are forced aligned.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(MEM_WORDS - 1);

  lsu_state_t  state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [15:0] r_wdata;
  logic        mem_wr_q;

  logic [ADDR_W-1:0] req_idx;
  logic              req_bad;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              unused_addr_hi;

  assign req_ready      = (state == IDLE);
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  // A write never reaches memory in a cycle where reset is asserted
  assign mem_wr         = mem_wr_q & ~rst;

  // Word index and request error classification at acceptance
  always_comb begin
    req_idx = req_addr[ADDR_W+1:2] & IDX_MASK;
`ifdef LSU_MISALIGN_TRAP_EN
    req_bad = !f3_legal(req_we, req_funct3) || misaligned(req_funct3[1:0], req_addr[1:0]);
`else
    req_bad = !f3_legal(req_we, req_funct3);
`endif
  end

  lsu_align u_align (
    .funct3     (r_funct3),
    .addr_lo    (r_addr_lo),
    .word       (mem_rdata),
    .wdata      (r_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Request sequencing FSM with registered memory and response outputs.
  // mem_addr/mem_wdata/mem_wr are loaded one state early so they are
  // stable during the state that performs the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      r_funct3   <= '0;
      r_addr_lo  <= '0;
      r_wdata    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      mem_wr_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_funct3  <= req_funct3;
            r_addr_lo <= req_addr[1:0];
            r_wdata   <= req_wdata[15:0];
            mem_addr  <= {{(32-ADDR_W){1'b0}}, req_idx};
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_funct3 == F3_W) begin
              mem_wdata <= req_wdata;
              mem_wr_q  <= 1'b1;
              state     <= STORE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
          state      <= IDLE;
        end
        STORE: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        RMW_RD: begin
          mem_wdata <= merge_data;
          mem_wr_q  <= 1'b1;
          state     <= RMW_WR;
        end
        RMW_WR: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
